// File: rtl/ov7670_capture_scaler.sv
// ov7670_capture_scaler: OV7670 RGB565 capture with per-frame KxK box averaging (K=1/2/4) into a linear frame BRAM.
// Define OV_CAPTURE_ROUND_EN to round averages half-up instead of truncating.
module ov7670_capture_scaler #(
  parameter int SRC_H = 640,
  parameter int SRC_V = 480,
  parameter int ADDR_W = 19,
  parameter bit HI_BYTE_FIRST = 1'b1,
  parameter bit BGR_ORDER = 1'b0
) (
  input  logic              pclk,
  input  logic              rst_n,
  input  logic              vsync,
  input  logic              href,
  input  logic [7:0]        d,
  input  logic [1:0]        decim_sel,
  output logic [ADDR_W-1:0] addr,
  output logic [15:0]       dout,
  output logic              we,
  output logic              frame_done,
  output logic              frame_err
);
  localparam int XW = $clog2(SRC_H + 2);
  localparam int YW = $clog2(SRC_V + 1);
  localparam int LN = SRC_H / 2;
  localparam int LW = $clog2(LN);
  localparam logic [XW-1:0] XMAX = XW'(SRC_H);
  localparam logic [YW-1:0] YMAX = YW'(SRC_V);

  // Per-channel add of packed {R9,G10,B9} sums.
  function automatic logic [27:0] add3(input logic [27:0] a, input logic [27:0] b);
    return {a[27:19] + b[27:19], a[18:9] + b[18:9], a[8:0] + b[8:0]};
  endfunction

  logic              vsync_q, vsync_d, href_q, href_d, phase_q, phase_d;
  logic [7:0]        byte_q, byte_d;
  logic [15:0]       pix_q, pix_d;
  logic              pix_valid_q, pix_valid_d, active_q, active_d;
  logic [1:0]        ksel_q, ksel_d;
  logic [XW-1:0]     src_x_q, src_x_d;
  logic [YW-1:0]     src_y_q, src_y_d;
  logic [27:0]       hacc_q, hacc_d, sum_q, sum_d;
  logic              emit_q, emit_d, done_q, done_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       dout_q, dout_d;
  logic              we_q, we_d, frame_done_q, frame_done_d, frame_err_q, frame_err_d;
  logic [27:0]       lb_q [LN];
  logic              vs_rise, hr_rise, hr_fall, in_range, first_x, last_x, first_y, last_y;
  logic              lb_we, line_err, ovf;
  logic [1:0]        kmask, xm, ym;
  logic [27:0]       pix_ext, hsum, vsum, lb_rd, lb_wd;
  logic [LW-1:0]     lb_idx;
  logic [2:0]        sh;
  logic [3:0]        rnd;
  logic [4:0]        avg_r, avg_b;
  logic [5:0]        avg_g;
  logic [ADDR_W-1:0] last_addr;

  // Sync edge detection and byte-pair assembly into pix16.
  always_comb begin
    vs_rise = vsync & ~vsync_q;
    hr_rise = href & ~href_q;
    hr_fall = ~href & href_q;
    vsync_d = vsync;
    href_d = href;
    phase_d = href & ~phase_q & ~vs_rise;
    byte_d = (href & ~phase_q) ? d : byte_q;
    pix_d = (href & phase_q) ? (HI_BYTE_FIRST ? {byte_q, d} : {d, byte_q}) : pix_q;
    pix_valid_d = href & phase_q & ~vs_rise;
  end

  // Horizontal then vertical accumulation; last line of a block row emits the full KxK sum.
  always_comb begin
    kmask = ksel_q == 2'd2 ? 2'b11 : ksel_q == 2'd1 ? 2'b01 : 2'b00;
    xm = src_x_q[1:0] & kmask;
    ym = src_y_q[1:0] & kmask;
    first_x = xm == 2'b00;
    last_x = xm == kmask;
    first_y = ym == 2'b00;
    last_y = ym == kmask;
    in_range = active_q & pix_valid_q & (src_x_q < XMAX) & (src_y_q < YMAX);
    pix_ext = {4'd0, pix_q[15:11], 4'd0, pix_q[10:5], 4'd0, pix_q[4:0]};
    hsum = first_x ? pix_ext : add3(hacc_q, pix_ext);
    lb_idx = LW'(src_x_q >> ksel_q);
    lb_rd = lb_q[lb_idx];
    vsum = add3(lb_rd, hsum);
    hacc_d = in_range ? hsum : hacc_q;
    lb_wd = first_y ? hsum : vsum;
    lb_we = in_range & last_x & ~last_y;
    emit_d = in_range & last_x & last_y & ~vs_rise;
    sum_d = emit_d ? lb_wd : sum_q;
  end

  // Frame position counters, error tracking, averaging and write-port sequencing.
  always_comb begin
    active_d = active_q | vs_rise;
    ksel_d = vs_rise ? (decim_sel == 2'd3 ? 2'd1 : decim_sel) : ksel_q;
    src_x_d = (vs_rise | hr_rise) ? '0 : (active_q & pix_valid_q & (src_x_q <= XMAX)) ? src_x_q + XW'(1) : src_x_q;
    src_y_d = vs_rise ? '0 : (active_q & hr_fall & (src_y_q < YMAX)) ? src_y_q + YW'(1) : src_y_q;
    line_err = active_q & hr_fall & ((src_x_d != XMAX) | (src_y_q >= YMAX));
    last_addr = ADDR_W'(((SRC_H * SRC_V) >> {ksel_q, 1'b0}) - 1);
    sh = {ksel_q, 1'b0};
`ifdef OV_CAPTURE_ROUND_EN
    rnd = ksel_q == 2'd2 ? 4'd8 : ksel_q == 2'd1 ? 4'd2 : 4'd0;
`else
    rnd = 4'd0;
`endif
    avg_r = 5'((sum_q[27:19] + 9'(rnd)) >> sh);
    avg_g = 6'((sum_q[18:9] + 10'(rnd)) >> sh);
    avg_b = 5'((sum_q[8:0] + 9'(rnd)) >> sh);
    we_d = emit_q & ~done_q & ~vs_rise;
    ovf = emit_q & done_q & ~vs_rise;
    frame_done_d = we_d & (addr_q == last_addr);
    done_d = ~vs_rise & (done_q | frame_done_q);
    addr_d = vs_rise ? '0 : (we_q & (addr_q != last_addr)) ? addr_q + ADDR_W'(1) : addr_q;
    dout_d = we_d ? (BGR_ORDER ? {avg_b, avg_g, avg_r} : {avg_r, avg_g, avg_b}) : dout_q;
    frame_err_d = ~vs_rise & (frame_err_q | line_err | ovf);
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge pclk) begin
    if (!rst_n) begin
      vsync_q <= 1'b0;
      href_q <= 1'b0;
      phase_q <= 1'b0;
      byte_q <= '0;
      pix_q <= '0;
      pix_valid_q <= 1'b0;
      active_q <= 1'b0;
      ksel_q <= 2'd1;
      src_x_q <= '0;
      src_y_q <= '0;
      hacc_q <= '0;
      sum_q <= '0;
      emit_q <= 1'b0;
      done_q <= 1'b0;
      addr_q <= '0;
      dout_q <= '0;
      we_q <= 1'b0;
      frame_done_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      vsync_q <= vsync_d;
      href_q <= href_d;
      phase_q <= phase_d;
      byte_q <= byte_d;
      pix_q <= pix_d;
      pix_valid_q <= pix_valid_d;
      active_q <= active_d;
      ksel_q <= ksel_d;
      src_x_q <= src_x_d;
      src_y_q <= src_y_d;
      hacc_q <= hacc_d;
      sum_q <= sum_d;
      emit_q <= emit_d;
      done_q <= done_d;
      addr_q <= addr_d;
      dout_q <= dout_d;
      we_q <= we_d;
      frame_done_q <= frame_done_d;
      frame_err_q <= frame_err_d;
    end
  end

  // Line buffer of partial column sums; every entry is rewritten on the first line of each block row.
  always_ff @(posedge pclk) begin
    if (lb_we) lb_q[lb_idx] <= lb_wd;
  end

  assign addr = addr_q;
  assign dout = dout_q;
  assign we = we_q;
  assign frame_done = frame_done_q;
  assign frame_err = frame_err_q;
endmodule

// File: tb/tb_ov7670_capture_scaler.sv
// tb_ov7670_capture_scaler: scoreboard bench for the capture scaler on an 8x4 source.
module tb_ov7670_capture_scaler;
  localparam int H = 8;
  localparam int V = 4;
  localparam int AW = 5;
`ifdef OV_CAPTURE_ROUND_EN
  localparam logic [15:0] T2_EXP = 16'h1000;
`else
  localparam logic [15:0] T2_EXP = 16'h0800;
`endif

  logic pclk = 1'b0;
  logic rst_n, vsync, href;
  logic [7:0] d;
  logic [1:0] decim_sel;
  logic [AW-1:0] addr, addr2;
  logic [15:0] dout, dout2;
  logic we, we2, fd, fd2, fe, fe2;

  ov7670_capture_scaler #(.SRC_H(H), .SRC_V(V), .ADDR_W(AW), .HI_BYTE_FIRST(1'b1), .BGR_ORDER(1'b0)) u_dut (
    .pclk(pclk), .rst_n(rst_n), .vsync(vsync), .href(href), .d(d), .decim_sel(decim_sel),
    .addr(addr), .dout(dout), .we(we), .frame_done(fd), .frame_err(fe));

  ov7670_capture_scaler #(.SRC_H(H), .SRC_V(V), .ADDR_W(AW), .HI_BYTE_FIRST(1'b1), .BGR_ORDER(1'b1)) u_bgr (
    .pclk(pclk), .rst_n(rst_n), .vsync(vsync), .href(href), .d(d), .decim_sel(decim_sel),
    .addr(addr2), .dout(dout2), .we(we2), .frame_done(fd2), .frame_err(fe2));

  always #5 pclk = ~pclk;

  typedef struct {
    logic [AW-1:0] a;
    logic [15:0]   v;
    logic          dn;
    int            cyc;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [15:0] img [4][10];

  always @(posedge pclk) cyc <= cyc + 1;

  function automatic logic [15:0] swap_rb(input logic [15:0] v);
    return {v[4:0], v[10:5], v[15:11]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every write pops the oldest expected entry.
  always @(negedge pclk) begin
    exp_t e;
    if (we) begin
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: addr %0d dout 0x%04h with nothing expected", addr, dout);
      end else begin
        e = sb.pop_front();
        check("wr_addr", 32'(addr), 32'(e.a));
        check("wr_dout", 32'(dout), 32'(e.v));
        check("wr_frame_done", 32'(fd), 32'(e.dn));
        check("bgr_we", 32'(we2), 32'd1);
        check("bgr_dout", 32'(dout2), 32'(swap_rb(e.v)));
        if (e.cyc >= 0) check("wr_latency", 32'(cyc), 32'(e.cyc));
      end
    end else if (fd) begin
      errors++;
      $display("FAIL stray_frame_done: frame_done=1 while we=0 at cycle %0d", cyc);
    end
  end

  task automatic push(input int a, input logic [15:0] v, input logic dn, input int c);
    sb.push_back('{AW'(a), v, dn, c});
  endtask

  task automatic send_pix(input logic [15:0] p);
    @(negedge pclk);
    href = 1'b1;
    d = p[15:8];
    @(negedge pclk);
    d = p[7:0];
  endtask

  task automatic end_line();
    @(negedge pclk);
    href = 1'b0;
    d = 8'h00;
    repeat (4) @(negedge pclk);
  endtask

  task automatic send_line(input int y, input int n);
    for (int x = 0; x < n; x++) send_pix(img[y][x]);
    end_line();
  endtask

  task automatic new_frame(input logic [1:0] k);
    @(negedge pclk);
    decim_sel = k;
    vsync = 1'b1;
    repeat (2) @(negedge pclk);
    vsync = 1'b0;
    repeat (2) @(negedge pclk);
  endtask

  task automatic fill(input logic [15:0] v);
    for (int y = 0; y < 4; y++)
      for (int x = 0; x < 10; x++) img[y][x] = v;
  endtask

  task automatic full_frame();
    for (int y = 0; y < V; y++) send_line(y, H);
  endtask

  task automatic drain(input string name);
    repeat (6) @(negedge pclk);
    check(name, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    vsync = 1'b0;
    href = 1'b0;
    d = 8'h00;
    decim_sel = 2'd1;
    repeat (3) @(negedge pclk);
    check("rst_addr", 32'(addr), 32'd0);
    check("rst_dout", 32'(dout), 32'd0);
    check("rst_we", 32'(we), 32'd0);
    check("rst_frame_done", 32'(fd), 32'd0);
    check("rst_frame_err", 32'(fe), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge pclk);

    // K=2, constant white frame
    fill(16'hFFFF);
    for (int i = 0; i < 8; i++) push(i, 16'hFFFF, i == 7, -1);
    new_frame(2'd1);
    full_frame();
    drain("t1_queue_empty");
    check("t1_frame_err", 32'(fe), 32'd0);

    // K=2, red ramp 0..3 in block 0
    fill(16'h0000);
    img[0][1] = 16'h0800;
    img[1][0] = 16'h1000;
    img[1][1] = 16'h1800;
    push(0, T2_EXP, 1'b0, -1);
    for (int i = 1; i < 8; i++) push(i, 16'h0000, i == 7, -1);
    new_frame(2'd1);
    full_frame();
    drain("t2_queue_empty");

    // K=4, full green
    fill(16'h07E0);
    push(0, 16'h07E0, 1'b0, -1);
    push(1, 16'h07E0, 1'b1, -1);
    new_frame(2'd2);
    full_frame();
    drain("t3_queue_empty");

    // K=1 pass-through with latency check; first pixel pure red
    for (int y = 0; y < 4; y++)
      for (int x = 0; x < 10; x++) img[y][x] = 16'((y * 8 + x) * 16'h1357 + 16'h00F8);
    img[0][0] = 16'hF800;
    new_frame(2'd0);
    for (int y = 0; y < V; y++) begin
      for (int x = 0; x < H; x++) begin
        send_pix(img[y][x]);
        push(y * 8 + x, img[y][x], (y * 8 + x) == 31, cyc + 3);
      end
      end_line();
    end
    drain("t4_queue_empty");
    check("t4_frame_err", 32'(fe), 32'd0);

    // Long first line: extra pixels dropped, error sticky until vsync
    fill(16'h8410);
    for (int i = 0; i < 8; i++) push(i, 16'h8410, i == 7, -1);
    new_frame(2'd1);
    send_line(0, 10);
    check("t5_err_set", 32'(fe), 32'd1);
    for (int y = 1; y < V; y++) send_line(y, H);
    drain("t5_queue_empty");
    check("t5_err_sticky", 32'(fe), 32'd1);
    new_frame(2'd1);
    check("t5_err_clear", 32'(fe), 32'd0);

    // Abort after 3 writes, then reserved decim_sel (K=2) with a mid-frame change
    fill(16'h1234);
    for (int i = 0; i < 3; i++) push(i, 16'h1234, 1'b0, -1);
    new_frame(2'd1);
    send_line(0, H);
    send_line(1, 6);
    check("t6_err_short_line", 32'(fe), 32'd1);
    drain("t6_abort_queue_empty");
    fill(16'h39E7);
    for (int i = 0; i < 8; i++) push(i, 16'h39E7, i == 7, -1);
    new_frame(2'd3);
    check("t6_addr_zero", 32'(addr), 32'd0);
    check("t6_err_clear", 32'(fe), 32'd0);
    decim_sel = 2'd2;
    full_frame();
    drain("t6_queue_empty");
    check("t6_frame_err", 32'(fe), 32'd0);

    // Reset mid-line: outputs clear, no writes until next frame
    fill(16'h1234);
    push(0, 16'h1234, 1'b0, -1);
    new_frame(2'd1);
    send_line(0, H);
    for (int x = 0; x < 3; x++) send_pix(img[1][x]);
    @(negedge pclk);
    rst_n = 1'b0;
    @(negedge pclk);
    rst_n = 1'b1;
    check("t7_addr", 32'(addr), 32'd0);
    check("t7_dout", 32'(dout), 32'd0);
    check("t7_we", 32'(we), 32'd0);
    check("t7_frame_done", 32'(fd), 32'd0);
    check("t7_frame_err", 32'(fe), 32'd0);
    for (int x = 3; x < H; x++) send_pix(img[1][x]);
    end_line();
    send_line(2, H);
    send_line(3, H);
    drain("t7_no_writes");
    for (int i = 0; i < 8; i++) push(i, 16'h1234, i == 7, -1);
    new_frame(2'd1);
    full_frame();
    drain("t7_queue_empty");
    check("t7_frame_err_after", 32'(fe), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end
endmodule
